// File: rtl/program_loader_pkg.sv
// Shared types and sizes for the boot-time program loader.
package program_loader_pkg;

    localparam int WORD            = 32;
    localparam int HALF_WORD       = 16;
    localparam int LOADER_LEN_BITS = 16;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_LO  = 3'd1,
        LEN_HI  = 3'd2,
        DATA_LO = 3'd3,
        DATA_HI = 3'd4,
        RELEASE = 3'd5,
        RUN     = 3'd6,
        ERROR   = 3'd7
    } loader_state;

    // States in which a stream byte may be accepted.
    function automatic logic is_loading(input loader_state s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA_LO) || (s == DATA_HI);
    endfunction

endpackage

// File: rtl/program_loader_timeout_counter.sv
// Idle-cycle counter; expired_o flags the LIMIT-th consecutive enabled cycle without a clear.
module loader_timeout_counter #(
    parameter int unsigned LIMIT    = 65535,
    parameter int          CNT_BITS = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(LIMIT - 32'd1);

    logic [CNT_BITS-1:0] cnt_q;
    logic [CNT_BITS-1:0] cnt_d;

    // Clear has priority so a transfer always beats a coincident expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i & ~clear_i & (cnt_q == LAST);

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: streams a length-prefixed halfword image into instruction memory, then releases the CPU.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned MAX_INSTR     = 1024,
    parameter int unsigned ADDR_STEP     = 2,
    parameter int unsigned TIMEOUT       = 65535,
    parameter int unsigned RELEASE_DELAY = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic                 byte_valid_i,
    input  logic [7:0]           byte_i,
    output logic                 byte_ready_o,
    output logic                 program_mem_write_en_o,
    output logic [HALF_WORD-1:0] instruction_o,
    output logic [WORD-1:0]      instruction_addr_o,
    output logic                 cpu_reset_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o
);

    localparam logic [LOADER_LEN_BITS-1:0] MAX_W  = LOADER_LEN_BITS'(MAX_INSTR);
    localparam logic [LOADER_LEN_BITS-1:0] STEP_W = LOADER_LEN_BITS'(ADDR_STEP);
    localparam logic [7:0]                 REL_W  = 8'(RELEASE_DELAY);

    loader_state                state_q, state_d;
    logic [7:0]                 len_lo_q, len_lo_d;
    logic [7:0]                 data_lo_q, data_lo_d;
    logic [LOADER_LEN_BITS-1:0] remaining_q, remaining_d;
    logic [LOADER_LEN_BITS-1:0] addr_q, addr_d;
    logic [7:0]                 rel_cnt_q, rel_cnt_d;

    logic                 byte_ready_q, byte_ready_d;
    logic                 write_en_q, write_en_d;
    logic [HALF_WORD-1:0] instr_q, instr_d;
    logic [WORD-1:0]      instr_addr_q, instr_addr_d;
    logic                 cpu_reset_q, cpu_reset_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic                       xfer_s;
    logic                       start_ok_s;
    logic                       timeout_s;
    logic [LOADER_LEN_BITS-1:0] count_s;

    // byte_ready_q mirrors "state_q is a loading state", so this is the handshake.
    assign xfer_s     = byte_valid_i & byte_ready_q;
    assign start_ok_s = start_i & ((state_q == IDLE) || (state_q == RUN) || (state_q == ERROR));
    assign count_s    = {byte_i, len_lo_q};

    loader_timeout_counter #(
        .LIMIT    (TIMEOUT),
        .CNT_BITS (LOADER_LEN_BITS)
    ) u_timeout (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clear_i   (xfer_s | start_ok_s),
        .enable_i  (is_loading(state_q)),
        .expired_o (timeout_s)
    );

    // State register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and counter updates.
    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        data_lo_d   = data_lo_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        rel_cnt_d   = rel_cnt_q;
        case (state_q)
            IDLE, RUN, ERROR: begin
                if (start_ok_s) begin
                    state_d = LEN_LO;
                    addr_d  = '0;
                end else begin
                    state_d = state_q;
                end
            end
            LEN_LO: begin
                if (xfer_s) begin
                    len_lo_d = byte_i;
                    state_d  = LEN_HI;
                end else if (timeout_s) begin
                    state_d = ERROR;
                end else begin
                    state_d = LEN_LO;
                end
            end
            LEN_HI: begin
                if (xfer_s) begin
                    if ((count_s == '0) || (count_s > MAX_W)) begin
                        state_d = ERROR;
                    end else begin
                        remaining_d = count_s;
                        state_d     = DATA_LO;
                    end
                end else if (timeout_s) begin
                    state_d = ERROR;
                end else begin
                    state_d = LEN_HI;
                end
            end
            DATA_LO: begin
                if (xfer_s) begin
                    data_lo_d = byte_i;
                    state_d   = DATA_HI;
                end else if (timeout_s) begin
                    state_d = ERROR;
                end else begin
                    state_d = DATA_LO;
                end
            end
            DATA_HI: begin
                if (xfer_s) begin
                    remaining_d = remaining_q - {{(LOADER_LEN_BITS-1){1'b0}}, 1'b1};
                    addr_d      = addr_q + STEP_W;
                    if (remaining_q == {{(LOADER_LEN_BITS-1){1'b0}}, 1'b1}) begin
                        rel_cnt_d = 8'd0;
                        state_d   = RELEASE;
                    end else begin
                        state_d = DATA_LO;
                    end
                end else if (timeout_s) begin
                    state_d = ERROR;
                end else begin
                    state_d = DATA_HI;
                end
            end
            RELEASE: begin
                // The cycle of the final strobe is count 0, so reset drops RELEASE_DELAY+1 cycles later.
                if (rel_cnt_q == REL_W) begin
                    state_d = RUN;
                end else begin
                    rel_cnt_d = rel_cnt_q + 8'd1;
                    state_d   = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode, computed one cycle ahead so every port is a flop.
    always_comb begin
        write_en_d   = 1'b0;
        instr_d      = instr_q;
        instr_addr_d = instr_addr_q;
        if ((state_q == DATA_HI) && xfer_s) begin
            write_en_d   = 1'b1;
            instr_d      = {byte_i, data_lo_q};
            instr_addr_d = {{(WORD-LOADER_LEN_BITS){1'b0}}, addr_q};
        end else begin
            write_en_d = 1'b0;
        end
        byte_ready_d = is_loading(state_d);
        busy_d       = is_loading(state_d) || (state_d == RELEASE);
        cpu_reset_d  = (state_d != RUN);
        done_d       = (state_d == RUN);
        error_d      = (state_d == ERROR);
    end

    // Datapath registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            len_lo_q    <= 8'd0;
            data_lo_q   <= 8'd0;
            remaining_q <= '0;
            addr_q      <= '0;
            rel_cnt_q   <= 8'd0;
        end else begin
            len_lo_q    <= len_lo_d;
            data_lo_q   <= data_lo_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            rel_cnt_q   <= rel_cnt_d;
        end
    end

    // Output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            byte_ready_q <= 1'b0;
            write_en_q   <= 1'b0;
            instr_q      <= '0;
            instr_addr_q <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            byte_ready_q <= byte_ready_d;
            write_en_q   <= write_en_d;
            instr_q      <= instr_d;
            instr_addr_q <= instr_addr_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready_o           = byte_ready_q;
    assign program_mem_write_en_o = write_en_q;
    assign instruction_o          = instr_q;
    assign instruction_addr_o     = instr_addr_q;
    assign cpu_reset_o            = cpu_reset_q;
    assign busy_o                 = busy_q;
    assign done_o                 = done_q;
    assign error_o                = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: normal loads, bad counts, idle timeout, restart, throttling and mid-load reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        start_i;
    logic        byte_valid_i;
    logic [7:0]  byte_i;
    logic        byte_ready_o;
    logic        program_mem_write_en_o;
    logic [15:0] instruction_o;
    logic [31:0] instruction_addr_o;
    logic        cpu_reset_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    int          n_cmp  = 0;
    int          n_bad  = 0;
    int          stalls = 0;
    int          n_rel;
    logic [31:0] wr_q [$];
    logic [7:0]  stream [$];

    always #5 clk = ~clk;

    program_loader #(
        .MAX_INSTR     (1024),
        .ADDR_STEP     (2),
        .TIMEOUT       (16),
        .RELEASE_DELAY (4)
    ) dut (
        .clk_i                  (clk),
        .reset_n_i              (reset_n_i),
        .start_i                (start_i),
        .byte_valid_i           (byte_valid_i),
        .byte_i                 (byte_i),
        .byte_ready_o           (byte_ready_o),
        .program_mem_write_en_o (program_mem_write_en_o),
        .instruction_o          (instruction_o),
        .instruction_addr_o     (instruction_addr_o),
        .cpu_reset_o            (cpu_reset_o),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .error_o                (error_o)
    );

    // Log every strobe as {addr[15:0], data}; one entry per strobe cycle.
    always @(negedge clk) begin
        if (program_mem_write_en_o === 1'b1) begin
            wr_q.push_back({instruction_addr_o[15:0], instruction_o});
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit thr);
        int n;
        if (thr && ($urandom_range(0, 1) == 1)) begin
            byte_valid_i = 1'b0;
            byte_i       = 8'h5A;
            tick();
        end
        byte_valid_i = 1'b1;
        byte_i       = b;
        n            = 0;
        while ((byte_ready_o !== 1'b1) && (n < 40)) begin
            tick();
            n++;
            stalls++;
        end
        if (n >= 40) begin
            check("ready_wait", {31'd0, byte_ready_o}, 32'd1);
        end
        tick();
        byte_valid_i = 1'b0;
    endtask

    task automatic send_stream(input bit thr);
        foreach (stream[i]) begin
            send_byte(stream[i], thr);
        end
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while ((cpu_reset_o === 1'b1) && (n < 30)) begin
            tick();
            n++;
        end
    endtask

    task automatic check_wr(input string tag, input logic [15:0] addr, input logic [15:0] data);
        logic [31:0] got;
        if (wr_q.size() > 0) begin
            got = wr_q.pop_front();
        end else begin
            got = 32'hDEAD_DEAD;
        end
        check(tag, got, {addr, data});
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_ready"}, {31'd0, byte_ready_o}, 32'd0);
        check({pfx, "_we"},    {31'd0, program_mem_write_en_o}, 32'd0);
        check({pfx, "_instr"}, {16'd0, instruction_o}, 32'd0);
        check({pfx, "_addr"},  instruction_addr_o, 32'd0);
        check({pfx, "_cpurst"}, {31'd0, cpu_reset_o}, 32'd1);
        check({pfx, "_busy"},  {31'd0, busy_o}, 32'd0);
        check({pfx, "_done"},  {31'd0, done_o}, 32'd0);
        check({pfx, "_err"},   {31'd0, error_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i    = 1'b0;
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        byte_i       = 8'h00;
        #12;
        check_reset_values("rst");
        @(negedge clk);
        reset_n_i = 1'b1;
        tick();
        tick();

        // Two halfwords at full rate.
        pulse_start();
        check("t1_ready_after_start", {31'd0, byte_ready_o}, 32'd1);
        check("t1_cpurst_load", {31'd0, cpu_reset_o}, 32'd1);
        check("t1_busy_load", {31'd0, busy_o}, 32'd1);
        stalls = 0;
        stream = '{8'h02, 8'h00, 8'h01, 8'h20, 8'h02, 8'h21};
        send_stream(1'b0);
        check("t1_stalls", stalls, 32'd0);
        check("t1_we", {31'd0, program_mem_write_en_o}, 32'd1);
        check("t1_instr", {16'd0, instruction_o}, 32'h2102);
        check("t1_addr", instruction_addr_o, 32'd2);
        wait_run(n_rel);
        check("t1_release_cycles", n_rel, 32'd5);
        check("t1_done", {31'd0, done_o}, 32'd1);
        check("t1_busy_run", {31'd0, busy_o}, 32'd0);
        check("t1_nwr", wr_q.size(), 32'd2);
        check_wr("t1_wr0", 16'h0000, 16'h2001);
        check_wr("t1_wr1", 16'h0002, 16'h2102);

        // Restart from RUN, with a start pulse mid-load that must be ignored.
        pulse_start();
        check("t3_cpurst", {31'd0, cpu_reset_o}, 32'd1);
        check("t3_done", {31'd0, done_o}, 32'd0);
        stream = '{8'h01, 8'h00, 8'h34};
        send_stream(1'b0);
        pulse_start();
        check("t3_busy_after_mid_start", {31'd0, busy_o}, 32'd1);
        check("t3_ready_after_mid_start", {31'd0, byte_ready_o}, 32'd1);
        send_byte(8'h12, 1'b0);
        wait_run(n_rel);
        check("t3_release_cycles", n_rel, 32'd5);
        check("t3_done", {31'd0, done_o}, 32'd1);
        check("t3_nwr", wr_q.size(), 32'd1);
        check_wr("t3_wr0", 16'h0000, 16'h1234);

        // Zero count.
        pulse_start();
        stream = '{8'h00, 8'h00};
        send_stream(1'b0);
        check("t4_err", {31'd0, error_o}, 32'd1);
        check("t4_busy", {31'd0, busy_o}, 32'd0);
        check("t4_ready", {31'd0, byte_ready_o}, 32'd0);
        tick();
        tick();
        tick();
        check("t4_cpurst", {31'd0, cpu_reset_o}, 32'd1);
        check("t4_done", {31'd0, done_o}, 32'd0);
        check("t4_err_held", {31'd0, error_o}, 32'd1);
        check("t4_nwr", wr_q.size(), 32'd0);

        // Count 1025 exceeds the limit.
        pulse_start();
        check("t5_err_cleared", {31'd0, error_o}, 32'd0);
        stream = '{8'h01, 8'h04};
        send_stream(1'b0);
        check("t5_err", {31'd0, error_o}, 32'd1);
        tick();
        check("t5_cpurst", {31'd0, cpu_reset_o}, 32'd1);
        check("t5_nwr", wr_q.size(), 32'd0);

        // Idle timeout after a partial halfword, then a clean reload.
        pulse_start();
        stream = '{8'h03, 8'h00, 8'hAA};
        send_stream(1'b0);
        repeat (15) tick();
        check("t6_err_before", {31'd0, error_o}, 32'd0);
        check("t6_busy_before", {31'd0, busy_o}, 32'd1);
        tick();
        check("t6_err_at_16", {31'd0, error_o}, 32'd1);
        check("t6_busy_after", {31'd0, busy_o}, 32'd0);
        check("t6_cpurst", {31'd0, cpu_reset_o}, 32'd1);
        check("t6_nwr", wr_q.size(), 32'd0);
        pulse_start();
        stream = '{8'h01, 8'h00, 8'hCD, 8'hAB};
        send_stream(1'b0);
        wait_run(n_rel);
        check("t6_done", {31'd0, done_o}, 32'd1);
        check("t6_err_clear", {31'd0, error_o}, 32'd0);
        check("t6_nwr", wr_q.size(), 32'd1);
        check_wr("t6_wr0", 16'h0000, 16'hABCD);

        // Throttled stream.
        pulse_start();
        stream = '{8'h03, 8'h00, 8'h21, 8'h43, 8'h65, 8'h87, 8'hA9, 8'hCB};
        send_stream(1'b1);
        wait_run(n_rel);
        check("t7_done", {31'd0, done_o}, 32'd1);
        check("t7_nwr", wr_q.size(), 32'd3);
        check_wr("t7_wr0", 16'h0000, 16'h4321);
        check_wr("t7_wr1", 16'h0002, 16'h8765);
        check_wr("t7_wr2", 16'h0004, 16'hCBA9);

        // Reset asserted while waiting in DATA_HI.
        pulse_start();
        stream = '{8'h02, 8'h00, 8'h55, 8'h44, 8'h77};
        send_stream(1'b1);
        check("t8_instr_before", {16'd0, instruction_o}, 32'h4455);
        byte_valid_i = 1'b1;
        byte_i       = 8'h88;
        #2;
        reset_n_i = 1'b0;
        #1;
        check_reset_values("t8_rst");
        @(negedge clk);
        byte_valid_i = 1'b0;
        reset_n_i    = 1'b1;
        tick();
        tick();
        check("t8_idle_ready", {31'd0, byte_ready_o}, 32'd0);
        check("t8_idle_cpurst", {31'd0, cpu_reset_o}, 32'd1);
        check("t8_nwr", wr_q.size(), 32'd1);
        check_wr("t8_wr0", 16'h0000, 16'h4455);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
